// File: rtl/hpi_txn_sched_pkg.sv
// Shared types and constants for the CY7C67200 HPI transaction scheduler.
// Holds the sequencer state encoding, HPI register selects and counter helpers.
package hpi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } hpi_state_t;

  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDR    = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

  localparam int HPI_CNT_W = 4;
  typedef logic [HPI_CNT_W-1:0] hpi_cnt_t;

  // Counter load value for a phase lasting n cycles; a zero-length phase loads 0.
  function automatic hpi_cnt_t cyc_load(input int unsigned n);
    return (n == 0) ? '0 : hpi_cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/hpi_txn_sched_rr_arb2.sv
// Two-input round-robin arbiter: on contention the port that did not win last time is granted.
module hpi_rr_arb2
  import hpi_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic enable,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = enable & (req0 | req1);
  assign grant_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/hpi_txn_sched.sv
// Arbitrates two single-word HPI requesters and sequences the active-low
// from_sw_* strobes with programmable setup, strobe, hold and recovery timing.
module hpi_txn_sched
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 3,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  addr0,
  input  logic [15:0] wdata0,
  output logic        done0,
  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  from_sw_address,
  output logic [15:0] from_sw_data_out,
  input  logic [15:0] from_sw_data_in,
  output logic        from_sw_cs,
  output logic        from_sw_r,
  output logic        from_sw_w
);

  localparam hpi_cnt_t CNT_SETUP   = cyc_load(SETUP_CYC);
  localparam hpi_cnt_t CNT_STROBE  = cyc_load(STROBE_CYC);
  localparam hpi_cnt_t CNT_HOLD    = cyc_load(HOLD_CYC);
  localparam hpi_cnt_t CNT_RECOVER = cyc_load(RECOVER_CYC);

  hpi_state_t  state, state_nxt;
  hpi_cnt_t    cnt, cnt_nxt;
  logic        last_grant;
  logic        grant_valid;
  logic        grant_id;
  logic        gid_q;
  logic        we_q;
  logic        hold_done;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;

  hpi_rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .enable      (state == IDLE),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CNT_STROBE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          hold_done = 1'b1;
          state_nxt = (RECOVER_CYC == 0) ? IDLE : RECOVER;
          cnt_nxt   = CNT_RECOVER;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gid_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done0 <= hold_done & ~gid_q;
      done1 <= hold_done & gid_q;
      if (grant_valid) begin
        last_grant <= grant_id;
        gid_q      <= grant_id;
        we_q       <= grant_id ? we1    : we0;
        addr_q     <= grant_id ? addr1  : addr0;
        wdata_q    <= grant_id ? wdata1 : wdata0;
      end
      // The I/O interface data path is two registers deep; the last HOLD cycle sees it settled.
      if (hold_done && !we_q) begin
        rdata <= from_sw_data_in;
      end
    end
  end

  assign busy             = (state != IDLE);
  assign from_sw_cs       = !(state inside {SETUP, STROBE, HOLD});
  assign from_sw_r        = !((state == STROBE) && !we_q);
  assign from_sw_w        = !((state == STROBE) && we_q);
  assign from_sw_address  = addr_q;
  assign from_sw_data_out = wdata_q;

endmodule

// File: tb/tb_hpi_txn_sched.sv
// Self-checking bench for hpi_txn_sched: bus monitor plus a transaction-level
// round-robin model; a second instance covers the fast timing configuration.
module tb_hpi_txn_sched;

  localparam int CS_LEN_A = 6;   // 1 + 3 + 2
  localparam int PERIOD_A = 9;   // 1 + 1 + 3 + 2 + 2
  localparam int CS_LEN_B = 5;   // 2 + 1 + 2
  localparam int PERIOD_B = 6;   // 1 + 2 + 1 + 2 + 0

  typedef struct { bit we; logic [1:0] addr; logic [15:0] wdata; } req_t;
  typedef struct { int port; bit we; logic [1:0] addr; logic [15:0] wdata; } exp_t;
  typedef struct { int port; int cyc; logic [15:0] rdata; } done_t;
  typedef struct {
    int idx; int start; int stop; int cs_len;
    int r_off; int r_len; int w_off; int w_len;
    logic [1:0] addr; logic [15:0] data; bit stable;
  } obs_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic req0, we0, req1, we1, done0, done1, busy;
  logic [1:0] addr0, addr1, from_sw_address;
  logic [15:0] wdata0, wdata1, rdata, from_sw_data_out, data_in_a;
  logic from_sw_cs, from_sw_r, from_sw_w;

  logic reqb0, web0, reqb1, doneb0, doneb1, busy_b;
  logic [1:0] addrb0, addrb1, addr_out_b;
  logic [15:0] wdatab0, wdatab1, rdata_b, data_out_b, data_in_b;
  logic cs_b, r_b, w_b;

  hpi_txn_sched dut_a (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .busy(busy),
    .from_sw_address(from_sw_address), .from_sw_data_out(from_sw_data_out),
    .from_sw_data_in(data_in_a), .from_sw_cs(from_sw_cs),
    .from_sw_r(from_sw_r), .from_sw_w(from_sw_w)
  );

  hpi_txn_sched #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVER_CYC(0)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .req0(reqb0), .we0(web0), .addr0(addrb0), .wdata0(wdatab0), .done0(doneb0),
    .req1(reqb1), .we1(1'b0), .addr1(addrb1), .wdata1(wdatab1), .done1(doneb1),
    .rdata(rdata_b), .busy(busy_b),
    .from_sw_address(addr_out_b), .from_sw_data_out(data_out_b),
    .from_sw_data_in(data_in_b), .from_sw_cs(cs_b),
    .from_sw_r(r_b), .from_sw_w(w_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int viol     = 0;
  int obs_idx  = 0;
  bit in_txn   = 1'b0;
  logic [15:0] rd_seed = 16'h0;
  obs_t  cur;
  obs_t  obs_q[$];
  done_t done_q[$];
  req_t  plan0[$];
  req_t  plan1[$];
  exp_t  exp_q[$];

  bit in_b = 1'b0;
  int len_b = 0;
  int b_start_q[$];
  int b_len_q[$];

  // Read data the HPI model returns for the idx-th transaction of a run.
  function automatic logic [15:0] rd_val(input int idx, input logic [1:0] a);
    logic [13:0] i14;
    i14 = 14'(idx);
    return rd_seed ^ {i14, a};
  endfunction

  // Bus monitor for the default-timing instance; also plays the HPI side of reads.
  always @(negedge Clk) begin
    cyc++;
    if (from_sw_cs === 1'b0) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        cur.idx = obs_idx; obs_idx++;
        cur.start = cyc; cur.stop = 0; cur.cs_len = 0;
        cur.r_off = -1; cur.r_len = 0; cur.w_off = -1; cur.w_len = 0;
        cur.addr = from_sw_address; cur.data = from_sw_data_out; cur.stable = 1'b1;
      end
      cur.cs_len++;
      if (from_sw_address !== cur.addr || from_sw_data_out !== cur.data) cur.stable = 1'b0;
      if (from_sw_w === 1'b0) begin
        if (cur.w_len == 0) cur.w_off = cyc - cur.start;
        cur.w_len++;
      end
      if (from_sw_r === 1'b0) begin
        if (cur.r_len == 0) cur.r_off = cyc - cur.start;
        cur.r_len++;
      end
    end else if (in_txn) begin
      in_txn = 1'b0;
      cur.stop = cyc;
      obs_q.push_back(cur);
    end
    if (from_sw_r === 1'b0 && from_sw_w === 1'b0) viol++;
    if (from_sw_cs !== 1'b0 && (from_sw_r !== 1'b1 || from_sw_w !== 1'b1)) viol++;
    if (done0 === 1'b1 && done1 === 1'b1) viol++;
    if (done0 === 1'b1) done_q.push_back('{0, cyc, rdata});
    if (done1 === 1'b1) done_q.push_back('{1, cyc, rdata});
    if (in_txn && from_sw_r === 1'b1 && from_sw_w === 1'b1 && (cur.r_len + cur.w_len) > 0)
      data_in_a = rd_val(cur.idx, cur.addr);
    else
      data_in_a = 16'hDEAD;
  end

  always @(negedge Clk) begin
    if (cs_b === 1'b0) begin
      if (!in_b) begin
        in_b = 1'b1; len_b = 0;
        b_start_q.push_back(cyc);
      end
      len_b++;
    end else if (in_b) begin
      in_b = 1'b0;
      b_len_q.push_back(len_b);
    end
  end

  task automatic clear_mon();
    obs_q.delete(); done_q.delete(); viol = 0; obs_idx = 0;
    b_start_q.delete(); b_len_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; req0 = 1'b0; req1 = 1'b0; reqb0 = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // Transaction-level round-robin: alternate while both ports have work, then drain.
  task automatic build_expected(input bit last_in);
    req_t p0[$];
    req_t p1[$];
    req_t r;
    bit last;
    int port;
    p0 = plan0; p1 = plan1; last = last_in; exp_q.delete();
    while (p0.size() > 0 || p1.size() > 0) begin
      if (p0.size() > 0 && p1.size() > 0) port = last ? 0 : 1;
      else port = (p0.size() > 0) ? 0 : 1;
      if (port == 0) r = p0.pop_front(); else r = p1.pop_front();
      exp_q.push_back('{port, r.we, r.addr, r.wdata});
      last = (port == 1);
    end
  endtask

  // Each requester keeps req high and presents its next item in the done cycle.
  task automatic run_plans(input int budget);
    fork
      begin
        int t;
        while (plan0.size() > 0) begin
          req0 = 1'b1; we0 = plan0[0].we; addr0 = plan0[0].addr; wdata0 = plan0[0].wdata;
          t = 0;
          do begin @(negedge Clk); t++; end while (done0 !== 1'b1 && t < budget);
          if (done0 !== 1'b1) begin
            n_checks++;
            $display("FAIL drv0_timeout: no done0 within %0d cycles", budget);
            plan0.delete();
          end else void'(plan0.pop_front());
        end
        req0 = 1'b0;
      end
      begin
        int t;
        while (plan1.size() > 0) begin
          req1 = 1'b1; we1 = plan1[0].we; addr1 = plan1[0].addr; wdata1 = plan1[0].wdata;
          t = 0;
          do begin @(negedge Clk); t++; end while (done1 !== 1'b1 && t < budget);
          if (done1 !== 1'b1) begin
            n_checks++;
            $display("FAIL drv1_timeout: no done1 within %0d cycles", budget);
            plan1.delete();
          end else void'(plan1.pop_front());
        end
        req1 = 1'b0;
      end
    join
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    reqb0 = 0; web0 = 0; addrb0 = 0; wdatab0 = 0; reqb1 = 0; addrb1 = 0; wdatab1 = 0;
    data_in_b = 16'h0;
    repeat (3) @(negedge Clk);
    n_checks++; if ({from_sw_cs, from_sw_r, from_sw_w} !== 3'b111) $display("FAIL rst_strobes got %b want 111", {from_sw_cs, from_sw_r, from_sw_w}); else n_pass++;
    n_checks++; if (from_sw_address !== 2'd0) $display("FAIL rst_addr got %0d want 0", from_sw_address); else n_pass++;
    n_checks++; if (from_sw_data_out !== 16'h0) $display("FAIL rst_data_out got %h want 0000", from_sw_data_out); else n_pass++;
    n_checks++; if (rdata !== 16'h0) $display("FAIL rst_rdata got %h want 0000", rdata); else n_pass++;
    n_checks++; if ({done0, done1, busy} !== 3'b000) $display("FAIL rst_done_busy got %b want 000", {done0, done1, busy}); else n_pass++;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++; if (busy !== 1'b0 || from_sw_cs !== 1'b1) $display("FAIL idle_no_req busy=%b cs=%b want 0/1", busy, from_sw_cs); else n_pass++;
  endtask

  task automatic test_port0_write();
    obs_t o;
    clear_mon();
    plan0.push_back('{1'b1, 2'd2, 16'h1234});
    run_plans(40);
    repeat (4) @(negedge Clk);
    n_checks++;
    if (obs_q.size() != 1 || done_q.size() != 1) begin
      $display("FAIL p0w_count obs=%0d done=%0d want 1/1", obs_q.size(), done_q.size());
      return;
    end
    n_pass++;
    o = obs_q[0];
    n_checks++; if (o.cs_len !== CS_LEN_A) $display("FAIL p0w_cs_len got %0d want %0d", o.cs_len, CS_LEN_A); else n_pass++;
    n_checks++; if (o.w_off !== 1 || o.w_len !== 3) $display("FAIL p0w_wstrobe off=%0d len=%0d want 1/3", o.w_off, o.w_len); else n_pass++;
    n_checks++; if (o.r_len !== 0) $display("FAIL p0w_rstrobe len=%0d want 0", o.r_len); else n_pass++;
    n_checks++; if (o.data !== 16'h1234 || o.addr !== 2'd2 || !o.stable) $display("FAIL p0w_bus data=%h addr=%0d stable=%0d want 1234/2/1", o.data, o.addr, o.stable); else n_pass++;
    n_checks++; if (done_q[0].port !== 0 || done_q[0].cyc !== o.stop) $display("FAIL p0w_done port=%0d cyc=%0d want 0/%0d", done_q[0].port, done_q[0].cyc, o.stop); else n_pass++;
    n_checks++; if (done_q[0].rdata !== 16'h0) $display("FAIL p0w_rdata_kept got %h want 0000", done_q[0].rdata); else n_pass++;
  endtask

  task automatic test_port1_read();
    obs_t o;
    clear_mon();
    rd_seed = 16'hBEEF;
    plan1.push_back('{1'b0, 2'd0, 16'h5555});
    run_plans(40);
    repeat (5) @(negedge Clk);
    n_checks++;
    if (obs_q.size() != 1 || done_q.size() != 1) begin
      $display("FAIL p1r_count obs=%0d done=%0d want 1/1", obs_q.size(), done_q.size());
      return;
    end
    n_pass++;
    o = obs_q[0];
    n_checks++; if (o.r_off !== 1 || o.r_len !== 3 || o.w_len !== 0) $display("FAIL p1r_strobes roff=%0d rlen=%0d wlen=%0d want 1/3/0", o.r_off, o.r_len, o.w_len); else n_pass++;
    n_checks++; if (done_q[0].port !== 1 || done_q[0].rdata !== 16'hBEEF) $display("FAIL p1r_done port=%0d rdata=%h want 1/beef", done_q[0].port, done_q[0].rdata); else n_pass++;
    n_checks++; if (rdata !== 16'hBEEF) $display("FAIL p1r_rdata_hold got %h want beef", rdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int want_ord[4] = '{0, 1, 0, 1};
    apply_reset();
    clear_mon();
    for (int i = 0; i < 2; i++) begin
      plan0.push_back('{1'b1, 2'(i), 16'hA000 + 16'(i)});
      plan1.push_back('{1'b0, 2'(i + 1), 16'hB000 + 16'(i)});
    end
    run_plans(40);
    repeat (5) @(negedge Clk);
    n_checks++;
    if (obs_q.size() != 4 || done_q.size() != 4) begin
      $display("FAIL b2b_count obs=%0d done=%0d want 4/4", obs_q.size(), done_q.size());
      return;
    end
    n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (done_q[i].port !== want_ord[i]) $display("FAIL b2b_order[%0d] got %0d want %0d", i, done_q[i].port, want_ord[i]); else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (obs_q[i].start - obs_q[i-1].start !== PERIOD_A) $display("FAIL b2b_period[%0d] got %0d want %0d", i, obs_q[i].start - obs_q[i-1].start, PERIOD_A); else n_pass++;
    end
    n_checks++; if (viol !== 0) $display("FAIL b2b_protocol violations=%0d want 0", viol); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t;
    apply_reset();
    clear_mon();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 16'hA5A5;
    t = 0;
    do begin @(negedge Clk); t++; end while (from_sw_w !== 1'b0 && t < 20);
    n_checks++; if (from_sw_w !== 1'b0) $display("FAIL rstmid_no_strobe w=%b want 0", from_sw_w); else n_pass++;
    Reset = 1'b1; req0 = 1'b0;
    @(negedge Clk);
    n_checks++; if ({from_sw_cs, from_sw_r, from_sw_w} !== 3'b111) $display("FAIL rstmid_strobes got %b want 111", {from_sw_cs, from_sw_r, from_sw_w}); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done0 !== 1'b0) $display("FAIL rstmid_busy_done busy=%b done0=%b want 0/0", busy, done0); else n_pass++;
    Reset = 1'b0;
    repeat (12) @(negedge Clk);
    n_checks++; if (done_q.size() !== 0) $display("FAIL rstmid_spurious_done got %0d want 0", done_q.size()); else n_pass++;
    clear_mon();
    plan0.push_back('{1'b1, 2'd3, 16'h0F0F});
    run_plans(40);
    repeat (4) @(negedge Clk);
    n_checks++;
    if (obs_q.size() !== 1 || done_q.size() !== 1 || obs_q[0].w_len !== 3 || obs_q[0].data !== 16'h0F0F)
      $display("FAIL rstmid_fresh obs=%0d done=%0d want 1/1 with 3-cycle write of 0f0f", obs_q.size(), done_q.size());
    else n_pass++;
  endtask

  task automatic test_req_drop();
    int t;
    clear_mon();
    rd_seed = 16'h3C5A;
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3; wdata0 = 16'h0;
    t = 0;
    do begin @(negedge Clk); t++; end while (from_sw_cs !== 1'b0 && t < 20);
    req0 = 1'b0;
    t = 0;
    while (done_q.size() == 0 && t < 30) begin @(negedge Clk); t++; end
    repeat (20) @(negedge Clk);
    n_checks++;
    if (obs_q.size() !== 1 || done_q.size() !== 1) begin
      $display("FAIL drop_count obs=%0d done=%0d want 1/1", obs_q.size(), done_q.size());
      return;
    end
    n_pass++;
    n_checks++; if (done_q[0].port !== 0 || done_q[0].rdata !== 16'h3C59) $display("FAIL drop_done port=%0d rdata=%h want 0/3c59", done_q[0].port, done_q[0].rdata); else n_pass++;
  endtask

  task automatic test_timing_override();
    int cnt;
    int t;
    clear_mon();
    reqb0 = 1'b1; web0 = 1'b1; addrb0 = 2'd1; wdatab0 = 16'h7777;
    cnt = 0; t = 0;
    while (cnt < 3 && t < 100) begin
      @(negedge Clk); t++;
      if (doneb0 === 1'b1) begin
        cnt++;
        if (cnt == 3) reqb0 = 1'b0;
      end
    end
    repeat (10) @(negedge Clk);
    n_checks++;
    if (cnt !== 3 || b_start_q.size() !== 3 || b_len_q.size() !== 3) begin
      $display("FAIL fast_count done=%0d txns=%0d want 3/3", cnt, b_start_q.size());
      reqb0 = 1'b0;
      return;
    end
    n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (b_len_q[i] !== CS_LEN_B) $display("FAIL fast_cs_len[%0d] got %0d want %0d", i, b_len_q[i], CS_LEN_B); else n_pass++;
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++; if (b_start_q[i] - b_start_q[i-1] !== PERIOD_B) $display("FAIL fast_period[%0d] got %0d want %0d", i, b_start_q[i] - b_start_q[i-1], PERIOD_B); else n_pass++;
    end
    n_checks++; if (busy_b !== 1'b0 || doneb1 !== 1'b0) $display("FAIL fast_idle busy=%b done1=%b want 0/0", busy_b, doneb1); else n_pass++;
  endtask

  task automatic test_random();
    int n0, n1;
    logic [15:0] exp_rd;
    apply_reset();
    clear_mon();
    rd_seed = 16'($urandom);
    n0 = $urandom_range(2, 5);
    n1 = $urandom_range(2, 5);
    for (int i = 0; i < n0; i++) plan0.push_back('{1'($urandom), 2'($urandom), 16'($urandom)});
    for (int i = 0; i < n1; i++) plan1.push_back('{1'($urandom), 2'($urandom), 16'($urandom)});
    build_expected(1'b1);
    run_plans(60);
    repeat (12) @(negedge Clk);
    n_checks++;
    if (obs_q.size() != exp_q.size() || done_q.size() != exp_q.size()) begin
      $display("FAIL rnd_count obs=%0d done=%0d want %0d", obs_q.size(), done_q.size(), exp_q.size());
      return;
    end
    n_pass++;
    exp_rd = 16'h0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (!exp_q[i].we) exp_rd = rd_val(i, exp_q[i].addr);
      n_checks++; if (done_q[i].port !== exp_q[i].port) $display("FAIL rnd_port[%0d] got %0d want %0d", i, done_q[i].port, exp_q[i].port); else n_pass++;
      n_checks++; if (obs_q[i].addr !== exp_q[i].addr || !obs_q[i].stable) $display("FAIL rnd_addr[%0d] got %0d stable=%0d want %0d", i, obs_q[i].addr, obs_q[i].stable, exp_q[i].addr); else n_pass++;
      n_checks++;
      if (exp_q[i].we ? (obs_q[i].w_len !== 3 || obs_q[i].r_len !== 0 || obs_q[i].data !== exp_q[i].wdata)
                      : (obs_q[i].r_len !== 3 || obs_q[i].w_len !== 0))
        $display("FAIL rnd_strobe[%0d] we=%0d rlen=%0d wlen=%0d data=%h want wdata %h", i, exp_q[i].we, obs_q[i].r_len, obs_q[i].w_len, obs_q[i].data, exp_q[i].wdata);
      else n_pass++;
      n_checks++; if (obs_q[i].cs_len !== CS_LEN_A) $display("FAIL rnd_cs_len[%0d] got %0d want %0d", i, obs_q[i].cs_len, CS_LEN_A); else n_pass++;
      n_checks++; if (done_q[i].rdata !== exp_rd || done_q[i].cyc !== obs_q[i].stop) $display("FAIL rnd_done[%0d] rdata=%h cyc=%0d want %h/%0d", i, done_q[i].rdata, done_q[i].cyc, exp_rd, obs_q[i].stop); else n_pass++;
      if (i > 0) begin
        n_checks++; if (obs_q[i].start - obs_q[i-1].start !== PERIOD_A) $display("FAIL rnd_period[%0d] got %0d want %0d", i, obs_q[i].start - obs_q[i-1].start, PERIOD_A); else n_pass++;
      end
    end
    n_checks++; if (viol !== 0) $display("FAIL rnd_protocol violations=%0d want 0", viol); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_port0_write();
    test_port1_read();
    test_back_to_back();
    test_reset_mid();
    test_req_drop();
    test_timing_override();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hpi_txn_sched.md
Name: hpi_txn_sched

Overview:
- Two-requester arbiter and transaction sequencer for the CY7C67200 HPI port.
- Accepts single-word read/write requests from two masters: port 0 (NIOS/software bridge) and port 1 (hardware USB poll engine).
- Arbitrates round-robin between them and drives the active-low from_sw_* strobes of the HPI I/O interface with programmable setup, strobe, hold and recovery timing.
- Returns read data and a one-cycle done pulse to the winning requester.

Parameters:
- SETUP_CYC, 1, cycles CS low with address valid before the RD/WR strobe falls (1..15).
- STROBE_CYC, 3, cycles RD_N/WR_N held low (1..15).
- HOLD_CYC, 2, cycles CS low after the strobe rises; read capture happens on the last one (>=2, covers the 2-cycle I/O-interface register latency).
- RECOVER_CYC, 2, cycles CS high between transactions (0..15).

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous active-high reset.
- req0, in, 1, port 0 request; held high until done0.
- we0, in, 1, port 0 direction: 1 = write, 0 = read.
- addr0, in, 2, port 0 HPI register select (0 DATA, 1 MAILBOX, 2 ADDR, 3 STATUS).
- wdata0, in, 16, port 0 write data.
- done0, out, 1, port 0 one-cycle completion pulse.
- req1/we1/addr1/wdata1/done1, same widths and meanings for port 1.
- rdata, out, 16, read data; valid in the cycle done0 or done1 pulses, then holds that value.
- busy, out, 1, high whenever state != IDLE.
- from_sw_address, out, 2, to the I/O interface.
- from_sw_data_out, out, 16, to the I/O interface.
- from_sw_data_in, in, 16, registered HPI data from the I/O interface.
- from_sw_cs, out, 1, active-low chip select.
- from_sw_r, out, 1, active-low read strobe.
- from_sw_w, out, 1, active-low write strobe; 1 = bus released.

Behaviour:
- Reset values: from_sw_cs, from_sw_r and from_sw_w = 1; from_sw_address = 0; from_sw_data_out = 0; rdata = 0; done0, done1 and busy = 0; last_grant = 1, so port 0 wins first; state IDLE; counter 0.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. A single 4-bit down-counter is loaded with N-1 on entry to each state; a state exits when the counter = 0.
- IDLE:
  - If any req is high, grant it. If both are high, grant the port != last_grant. Update last_grant.
  - Latch we, addr and wdata of the winner into internal registers. Go to SETUP.
  - Requests are sampled only in IDLE. A req that drops mid-transaction does not abort it.
- SETUP: cs = 0; address = latched addr; data_out = latched wdata. Strobes stay 1.
- STROBE: cs = 0. from_sw_w = 0 if write, otherwise from_sw_r = 0. Address and data stable.
- HOLD:
  - cs = 0; both strobes = 1; address and data stay stable.
  - On the last HOLD cycle, a read registers rdata <= from_sw_data_in. Writes leave rdata unchanged.
  - Exit to RECOVER, or straight to IDLE if RECOVER_CYC = 0.
- done pulse: done for the granted port pulses in the first cycle after leaving HOLD. The requester may drop req in that same cycle.
- RECOVER: cs = 1, strobes = 1. A new grant is possible only after RECOVER, in IDLE. Back-to-back transactions therefore occupy 1 + SETUP + STROBE + HOLD + RECOVER cycles each.
- from_sw_r and from_sw_w are never both 0. Strobes are never 0 while cs = 1.
- Reset asserted mid-transaction: returns to IDLE next cycle with all strobes high; no done pulse is issued for the aborted transaction.
- A requester holding req after done is treated as a new request.
- Starvation bound: a pending request is served within one competing transaction.

Decomposition:
- Package hpi_pkg:
  - typedef enum logic [2:0] hpi_state_t {IDLE, SETUP, STROBE, HOLD, RECOVER}.
  - localparams HPI_REG_DATA = 2'd0, HPI_REG_MAILBOX = 2'd1, HPI_REG_ADDR = 2'd2, HPI_REG_STATUS = 2'd3.
  - The 4-bit counter width.
- Sub-module hpi_rr_arb2: the two-input round-robin arbiter. Inputs req0, req1, the IDLE enable and last_grant; outputs grant_valid and grant_id.

Test Plan:
- Port 0 write: we0 = 1, addr0 = 2, wdata0 = 16'h1234, defaults.
  - Required: cs low 6 cycles; from_sw_w low for exactly 3 cycles starting 1 cycle after cs falls; from_sw_r stays 1; data_out = 16'h1234 throughout; done0 pulse once; the next transaction starts no earlier than 2 cycles after cs rises.
- Port 1 read: addr1 = 0; the model drives from_sw_data_in = 16'hBEEF during HOLD.
  - Required: from_sw_r low 3 cycles; from_sw_w stays 1; rdata = 16'hBEEF with the done1 pulse; rdata holds afterwards.
- Simultaneous req0 and req1 out of reset.
  - Required: port 0 is served first, then port 1.
  - With both held for 4 transactions, the grant sequence is 0, 1, 0, 1.
  - No cycle has r = 0 and w = 0 together, and no cycle has a strobe = 0 while cs = 1.
- Reset pulse during STROBE of a write.
  - Required: the next cycle has cs = r = w = 1, busy = 0, and no done pulse.
  - A fresh request after that completes normally.
- Timing override with SETUP_CYC = 2, STROBE_CYC = 1, HOLD_CYC = 2, RECOVER_CYC = 0.
  - Required: cs low exactly 5 cycles per transaction; back-to-back transactions are 6 cycles apart.
- req0 dropped during SETUP.
  - Required: the transaction still completes and done0 pulses.
  - No second transaction is issued for port 0.
